blk_ctrl: RTL and testbench
===========================

BLK_CTRL -- requirements
Module: blk_ctrl

Interface
REQ-001 Parameters (name, default, meaning); all steps are pixels per frame:
- STEP_X, 4, horizontal step in HOME.
- DROP_STEP, 8, downward step in DROP.
- RISE_STEP, 4, upward step in RISE, empty.
- RISE_SLOW, 2, upward step in RISE, grabbed.

REQ-002 Ports (name, direction, width, meaning):
- clk  in  1  pixel clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- frame_tick  in  1  one-cycle pulse, once per frame, at frame start.
- btn_l  in  1  move-left request, level, pre-debounced.
- btn_r  in  1  move-right request, level, pre-debounced.
- btn_fire  in  1  launch request, level, pre-debounced.
- grab  in  1  block overlaps a target, level.
- blkpos_x  out  11  block left edge, registered.
- blkpos_y  out  10  block top edge, registered.
- state  out  2  HOME=0, DROP=1, RISE=2; 3 never occurs.
- grabbed  out  1  target captured during the current launch.
- done  out  1  one-cycle pulse on return to HOME.
- score_inc  out  1  one-cycle pulse on return to HOME with grabbed=1.

Function
REQ-003 The block is 33x33 px (x..x+32, y..y+32). Legal range: X_MIN=10, X_MAX=1237, Y_MIN=10, Y_MAX=757, keeping the block inside the 10 px border of the 1280x800 frame.
REQ-004 All position and state updates occur only on the clk edge where frame_tick=1. Outputs change in the following cycle (1-cycle latency). Between ticks, position and state hold.
REQ-005 Arithmetic is done at width+1 bits. Each result clamps to the legal range, so there is no wrap-around at 0 or at the maximum.
REQ-006 HOME, on a tick:
- btn_l=1, btn_r=0: x = max(x-STEP_X, X_MIN).
- btn_r=1, btn_l=0: x = min(x+STEP_X, X_MAX).
- Both buttons or neither: x holds.
- y stays at Y_MIN.
REQ-007 fire_pend register:
- Set on a btn_fire rising edge (registered previous value) while state=HOME.
- Edges in DROP or RISE are ignored.
- Holding btn_fire does not re-arm.
REQ-008 HOME with fire_pend=1 on a tick (including an edge arriving in the same tick cycle): go to DROP, clear fire_pend, clear grabbed. x does not move in that tick.
REQ-009 DROP, on a tick:
- grab=1: set grabbed=1, go to RISE, y holds.
- Otherwise: y = min(y+DROP_STEP, Y_MAX); if the result equals Y_MAX, go to RISE.
- btn_l and btn_r are ignored.
REQ-010 RISE, on a tick:
- Step is RISE_SLOW if grabbed=1, otherwise RISE_STEP; y = max(y-step, Y_MIN).
- When the result equals Y_MIN: go to HOME, pulse done, and pulse score_inc if grabbed=1.
- grab is ignored.
REQ-011 done and score_inc are high for exactly the one cycle after the returning tick. grabbed holds until the next launch (REQ-008).
REQ-012 x is constant throughout DROP and RISE.

Reset
REQ-013 When rst=1 at a clk edge:
- blkpos_x=624, blkpos_y=10, state=HOME.
- grabbed, done, score_inc, fire_pend and the btn_fire history register = 0.
REQ-014 rst has priority over frame_tick and all buttons. Reset mid-DROP or mid-RISE returns to home on the next edge with no done pulse.

Verification
REQ-015 Reset, then btn_r held for 200 ticks -> x = 624, 628, ... saturating at 1237; y=10 throughout; btn_l+btn_r together -> x unchanged.
REQ-016 Fire pulse at x=624, grab=0 -> DROP. y: 10, 18, ..., 754, 757 (clamped) -> RISE. y: 753, ..., clamped to 10 -> HOME with done=1 for one cycle, score_inc=0.
REQ-017 Launch, grab=1 at the tick where y=106 -> RISE with grabbed=1. Rise in steps of 2 -> HOME; done and score_inc pulse together; grabbed stays 1 until the next fire.
REQ-018 btn_fire held high across the whole launch -> exactly one launch. A fire edge during DROP or RISE does not cause a relaunch after HOME.
REQ-019 rst asserted mid-RISE at y=400 -> next cycle x=624, y=10, HOME, no done. Frame_tick held 0 for 1000 cycles -> outputs constant.

Source files
------------

// File: rtl/blk_ctrl.sv
// rtl/blk_ctrl.sv - launch/drop/rise block controller updated once per frame tick
module blk_ctrl #(
    parameter int STEP_X    = 4,
    parameter int DROP_STEP = 8,
    parameter int RISE_STEP = 4,
    parameter int RISE_SLOW = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        btn_l,
    input  logic        btn_r,
    input  logic        btn_fire,
    input  logic        grab,
    output logic [10:0] blkpos_x,
    output logic [9:0]  blkpos_y,
    output logic [1:0]  state,
    output logic        grabbed,
    output logic        done,
    output logic        score_inc
);
    localparam logic [11:0] X_MIN  = 12'd10;
    localparam logic [11:0] X_MAX  = 12'd1237;
    localparam logic [10:0] Y_MIN  = 11'd10;
    localparam logic [10:0] Y_MAX  = 11'd757;
    localparam logic [10:0] X_HOME = 11'd624;

    typedef enum logic [1:0] {
        HOME = 2'd0,
        DROP = 2'd1,
        RISE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        grabbed_q, grabbed_d;
    logic        done_q, done_d;
    logic        score_q, score_d;
    logic        fire_pend_q, fire_pend_d;
    logic        fire_prev_q, fire_prev_d;

    logic        fire_edge;
    logic [11:0] x_sum, x_dif;
    logic [10:0] y_sum, y_dif, rise_amt;

    // One extra bit on every sum/difference so clamping sees overflow and underflow.
    always_comb begin
        fire_edge = btn_fire & ~fire_prev_q;
        rise_amt  = grabbed_q ? 11'(RISE_SLOW) : 11'(RISE_STEP);
        x_sum     = {1'b0, x_q} + 12'(STEP_X);
        x_dif     = {1'b0, x_q} - 12'(STEP_X);
        y_sum     = {1'b0, y_q} + 11'(DROP_STEP);
        y_dif     = {1'b0, y_q} - rise_amt;

        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        grabbed_d   = grabbed_q;
        done_d      = 1'b0;
        score_d     = 1'b0;
        fire_pend_d = fire_pend_q;
        fire_prev_d = btn_fire;

        if (frame_tick) begin
            case (state_q)
                HOME: begin
                    y_d = Y_MIN[9:0];
                    if (fire_pend_q || fire_edge) begin
                        state_d     = DROP;
                        fire_pend_d = 1'b0;
                        grabbed_d   = 1'b0;
                    end else if (btn_l && !btn_r) begin
                        x_d = (x_dif[11] || x_dif < X_MIN) ? X_MIN[10:0] : x_dif[10:0];
                    end else if (btn_r && !btn_l) begin
                        x_d = (x_sum > X_MAX) ? X_MAX[10:0] : x_sum[10:0];
                    end
                end
                DROP: begin
                    if (grab) begin
                        grabbed_d = 1'b1;
                        state_d   = RISE;
                    end else if (y_sum >= Y_MAX) begin
                        y_d     = Y_MAX[9:0];
                        state_d = RISE;
                    end else begin
                        y_d = y_sum[9:0];
                    end
                end
                RISE: begin
                    if (y_dif[10] || y_dif <= Y_MIN) begin
                        y_d     = Y_MIN[9:0];
                        state_d = HOME;
                        done_d  = 1'b1;
                        score_d = grabbed_q;
                    end else begin
                        y_d = y_dif[9:0];
                    end
                end
                default: state_d = HOME;
            endcase
        end else if (fire_edge && state_q == HOME) begin
            fire_pend_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HOME;
            x_q         <= X_HOME;
            y_q         <= Y_MIN[9:0];
            grabbed_q   <= 1'b0;
            done_q      <= 1'b0;
            score_q     <= 1'b0;
            fire_pend_q <= 1'b0;
            fire_prev_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            grabbed_q   <= grabbed_d;
            done_q      <= done_d;
            score_q     <= score_d;
            fire_pend_q <= fire_pend_d;
            fire_prev_q <= fire_prev_d;
        end
    end

    assign blkpos_x  = x_q;
    assign blkpos_y  = y_q;
    assign state     = state_q;
    assign grabbed   = grabbed_q;
    assign done      = done_q;
    assign score_inc = score_q;
endmodule

// File: tb/tb_blk_ctrl.sv
// tb/tb_blk_ctrl.sv - directed and random checks of blk_ctrl against a frame-level model
module tb_blk_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        btn_l = 1'b0;
    logic        btn_r = 1'b0;
    logic        btn_fire = 1'b0;
    logic        grab = 1'b0;
    logic [10:0] blkpos_x;
    logic [9:0]  blkpos_y;
    logic [1:0]  state;
    logic        grabbed, done, score_inc;

    int checks = 0;
    int failures = 0;

    int m_x, m_y, m_state, m_grabbed, m_done, m_score, m_pend, m_prev;
    bit m_valid = 0;

    int done_cnt = 0, score_cnt = 0, launch_cnt = 0;
    int prev_state = 0;

    blk_ctrl dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_l(btn_l), .btn_r(btn_r), .btn_fire(btn_fire), .grab(grab),
        .blkpos_x(blkpos_x), .blkpos_y(blkpos_y), .state(state),
        .grabbed(grabbed), .done(done), .score_inc(score_inc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            if (failures <= 30)
                $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: HOME walks x, DROP falls, RISE climbs; values are plain integers.
    always @(posedge clk) begin
        if (rst) begin
            m_x = 624; m_y = 10; m_state = 0;
            m_grabbed = 0; m_done = 0; m_score = 0; m_pend = 0; m_prev = 0;
            m_valid = 1;
        end else if (m_valid) begin
            int fire_rise;
            fire_rise = (btn_fire && !m_prev) ? 1 : 0;
            m_done = 0;
            m_score = 0;
            if (frame_tick) begin
                if (m_state == 0) begin
                    if (m_pend || fire_rise) begin
                        m_state = 1; m_pend = 0; m_grabbed = 0;
                    end else if (btn_l && !btn_r) begin
                        m_x = (m_x - 4 < 10) ? 10 : m_x - 4;
                    end else if (btn_r && !btn_l) begin
                        m_x = (m_x + 4 > 1237) ? 1237 : m_x + 4;
                    end
                end else if (m_state == 1) begin
                    if (grab) begin
                        m_grabbed = 1; m_state = 2;
                    end else begin
                        m_y = (m_y + 8 > 757) ? 757 : m_y + 8;
                        if (m_y == 757) m_state = 2;
                    end
                end else begin
                    m_y = m_y - (m_grabbed ? 2 : 4);
                    if (m_y < 10) m_y = 10;
                    if (m_y == 10) begin
                        m_state = 0; m_done = 1; m_score = m_grabbed;
                    end
                end
            end else if (fire_rise && m_state == 0) begin
                m_pend = 1;
            end
            m_prev = btn_fire;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("x", blkpos_x, m_x);
            chk("y", blkpos_y, m_y);
            chk("state", state, m_state);
            chk("grabbed", grabbed, m_grabbed);
            chk("done", done, m_done);
            chk("score_inc", score_inc, m_score);
            if (done) done_cnt++;
            if (score_inc) score_cnt++;
            if (state == 2'd1 && prev_state == 0) launch_cnt++;
            prev_state = state;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        cyc();
    endtask

    task automatic run_home(input int grab_at, input int bound, output int n, output int ymax);
        n = 0;
        ymax = 0;
        for (int i = 0; i < bound; i++) begin
            grab = (grab_at >= 0 && m_state == 1 && m_y == grab_at);
            tick();
            n++;
            if (int'(blkpos_y) > ymax) ymax = blkpos_y;
            if (state == 2'd0) break;
        end
        grab = 1'b0;
        if (state != 2'd0) chk("home_timeout", state, 0);
    endtask

    task automatic fire_pulse();
        btn_fire = 1'b1;
        cyc();
        btn_fire = 1'b0;
        cyc();
    endtask

    initial begin
        int n, ymax, d0, s0, l0;
        int sx, sy, ss, sg;
        rst = 1'b1;
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_x", blkpos_x, 624);
        chk("rst_y", blkpos_y, 10);
        chk("rst_state", state, 0);
        chk("rst_grabbed", grabbed, 0);

        // Walk right to the clamp, then both buttons, then left to the other clamp.
        btn_r = 1'b1;
        tick();
        chk("first_right", blkpos_x, 628);
        repeat (199) tick();
        chk("x_max_clamp", blkpos_x, 1237);
        chk("y_home", blkpos_y, 10);
        btn_l = 1'b1;
        repeat (5) tick();
        chk("both_hold", blkpos_x, 1237);
        btn_r = 1'b0;
        tick();
        chk("first_left", blkpos_x, 1233);
        repeat (400) tick();
        chk("x_min_clamp", blkpos_x, 10);
        btn_l = 1'b0;

        // Plain launch from x=624, no grab.
        rst = 1'b1; cyc(); rst = 1'b0; cyc();
        d0 = done_cnt; s0 = score_cnt;
        fire_pulse();
        run_home(-1, 400, n, ymax);
        chk("plain_ticks", n, 282);
        chk("plain_ymax", ymax, 757);
        chk("plain_done", done_cnt - d0, 1);
        chk("plain_score", score_cnt - s0, 0);
        chk("plain_x", blkpos_x, 624);

        // Grab at y=106, slow rise, grabbed sticks until next fire.
        d0 = done_cnt; s0 = score_cnt;
        fire_pulse();
        run_home(106, 400, n, ymax);
        chk("grab_ticks", n, 62);
        chk("grab_done", done_cnt - d0, 1);
        chk("grab_score", score_cnt - s0, 1);
        repeat (5) tick();
        chk("grabbed_sticky", grabbed, 1);
        fire_pulse();
        tick();
        chk("grabbed_clear", grabbed, 0);
        chk("relaunch_state", state, 1);
        run_home(-1, 400, n, ymax);

        // Fire held across a whole launch gives exactly one launch.
        l0 = launch_cnt;
        btn_fire = 1'b1;
        cyc();
        run_home(-1, 400, n, ymax);
        repeat (20) tick();
        chk("held_one_launch", launch_cnt - l0, 1);
        btn_fire = 1'b0;
        cyc();

        // Fire edges during DROP are ignored.
        l0 = launch_cnt;
        fire_pulse();
        tick(); tick();
        fire_pulse();
        fire_pulse();
        run_home(-1, 400, n, ymax);
        repeat (10) tick();
        chk("no_relaunch", launch_cnt - l0, 1);
        chk("no_relaunch_state", state, 0);

        // Reset mid-RISE at y=400 after moving x off home.
        btn_l = 1'b1;
        repeat (3) tick();
        btn_l = 1'b0;
        chk("moved_x", blkpos_x, 612);
        fire_pulse();
        for (int i = 0; i < 200; i++) begin
            if (m_state == 2 && m_y == 400) break;
            grab = (m_state == 1 && m_y == 410);
            tick();
        end
        grab = 1'b0;
        chk("rise_at_400", blkpos_y, 400);
        d0 = done_cnt;
        rst = 1'b1;
        frame_tick = 1'b1;
        cyc();
        rst = 1'b0;
        frame_tick = 1'b0;
        chk("midrise_x", blkpos_x, 624);
        chk("midrise_y", blkpos_y, 10);
        chk("midrise_state", state, 0);
        cyc(); cyc();
        chk("midrise_no_done", done_cnt - d0, 0);

        // No ticks for 1000 cycles: outputs frozen regardless of buttons.
        sx = blkpos_x; sy = blkpos_y; ss = state; sg = grabbed;
        repeat (1000) begin
            btn_l = 1'($urandom_range(0, 1));
            btn_r = 1'($urandom_range(0, 1));
            btn_fire = 1'($urandom_range(0, 1));
            grab = 1'($urandom_range(0, 1));
            cyc();
        end
        chk("idle_x", blkpos_x, sx);
        chk("idle_y", blkpos_y, sy);
        chk("idle_state", state, ss);
        chk("idle_grabbed", grabbed, sg);

        // Randomized traffic checked cycle-by-cycle against the model.
        repeat (6000) begin
            rst = ($urandom_range(0, 399) == 0);
            frame_tick = ($urandom_range(0, 2) == 0);
            btn_l = ($urandom_range(0, 2) == 0);
            btn_r = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 7) == 0) btn_fire = ~btn_fire;
            grab = ($urandom_range(0, 29) == 0);
            cyc();
        end
        rst = 1'b0; frame_tick = 1'b0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
